acl2_spi_arbiter: RTL

Shares the single ACL2 SPI register-transaction engine between NUM_REQ requesters, for example a configuration writer, an accelerometer sample poller and a debug register peeker. The engine runs back-to-back register transactions continuously. This block chooses the owner of each transaction and drives the engine operands. It returns completion and read data to the owner, and substitutes a harmless dummy read when nobody is requesting. A transaction watchdog detects an engine that stops signalling completion.

---
 rtl/acl2_spi_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/acl2_spi_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// acl2_spi_arbiter : round-robin ownership of the shared ACL2 SPI engine
// Revision : 1.0
// ---------------------------------------------------------------------------
module acl2_spi_arbiter #(
  parameter int         NUM_REQ   = 3,
  parameter int         TIMEOUT   = 48,
  parameter logic [7:0] IDLE_ADDR = 8'h00
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_read,
  input  logic [8*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [11:0]            rdata,
  output logic                   timeout_err,
  output logic                   eng_action_read,
  output logic [7:0]             eng_addr,
  output logic [7:0]             eng_din,
  input  logic                   eng_finished,
  input  logic [11:0]            eng_dout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // (base + off) mod NUM_REQ, with off < NUM_REQ
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  state_t               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [WW-1:0]        wd_q, wd_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [11:0]          rdata_q, rdata_d;
  logic                 terr_q, terr_d;
  logic                 op_read_q, op_read_d;
  logic [7:0]           op_addr_q, op_addr_d;
  logic [7:0]           op_din_q, op_din_d;

  logic [IW-1:0]        base;
  logic [IW-1:0]        cand;
  logic [IW-1:0]        win;
  logic                 found;
  logic                 excl;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    wd_d      = wd_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    terr_d    = terr_q;
    op_read_d = op_read_q;
    op_addr_d = op_addr_q;
    op_din_d  = op_din_q;
    base      = rr_q;
    cand      = '0;
    win       = '0;
    found     = 1'b0;
    excl      = 1'b0;

    if (wd_q != WD_LAST) wd_d = wd_q + 1'b1;

    if (eng_finished) begin
      wd_d = '0;
      if (state_q == S_BUSY) begin
        done_d[owner_q] = 1'b1;
        gnt_d           = '0;
        if (op_read_q) rdata_d = eng_dout;
        base = wrap_add(owner_q, 1);
        rr_d = base;
        excl = 1'b1;
      end
      // The just-finished owner is last in scan order, and skipped outright.
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = wrap_add(base, i);
        if (!found && req[cand] && !(excl && (cand == owner_q))) begin
          found = 1'b1;
          win   = cand;
        end
      end
      if (found) begin
        gnt_d[win] = 1'b1;
        owner_d    = win;
        op_read_d  = req_read[win];
        op_addr_d  = req_addr[8*win +: 8];
        op_din_d   = req_wdata[8*win +: 8];
        state_d    = S_BUSY;
      end else begin
        op_read_d = 1'b1;
        op_addr_d = IDLE_ADDR;
        op_din_d  = 8'h00;
        state_d   = S_IDLE;
      end
    end else if (wd_q == WD_LAST) begin
      terr_d = 1'b1;
      wd_d   = '0;
      if (state_q == S_BUSY) begin
        done_d[owner_q] = 1'b1;
        rdata_d         = '0;
        gnt_d           = '0;
        rr_d            = wrap_add(owner_q, 1);
      end
      op_read_d = 1'b1;
      op_addr_d = IDLE_ADDR;
      op_din_d  = 8'h00;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      wd_q      <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      terr_q    <= 1'b0;
      op_read_q <= 1'b1;
      op_addr_q <= IDLE_ADDR;
      op_din_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      wd_q      <= wd_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      terr_q    <= terr_d;
      op_read_q <= op_read_d;
      op_addr_q <= op_addr_d;
      op_din_q  <= op_din_d;
    end
  end

  assign gnt             = gnt_q;
  assign done            = done_q;
  assign rdata           = rdata_q;
  assign timeout_err     = terr_q;
  assign eng_action_read = op_read_q;
  assign eng_addr        = op_addr_q;
  assign eng_din         = op_din_q;

endmodule
`default_nettype wire
